// File: rtl/seq_adder_ctrl_pkg.sv
// rtl/seq_adder_ctrl_pkg.sv - shared constants and FSM encoding for the sequential adder
//
// Contents:
//   SLICE_W  width of the reusable carry-lookahead slice (one byte)
//   state_t  controller states IDLE / RUN / DONE

package seq_adder_ctrl_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Adder_LookAhead8.sv
// rtl/Adder_LookAhead8.sv - 8-bit carry-lookahead adder slice
//
// Ports:
//   a, b   [7:0]  slice operands
//   cin           carry into bit 0
//   sum    [7:0]  slice sum
//   cout          carry out of bit 7
//   c_msb         carry into bit 7 (needed by the caller for signed overflow)

import seq_adder_ctrl_pkg::*;

module Adder_LookAhead8 (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened sum-of-products of generate/propagate terms,
    // so no carry depends on a neighbouring carry (true lookahead, not ripple).
    always_comb begin
        logic acc;
        logic pp;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            acc    = acc | (pp & cin);
            c[i+1] = acc;
        end
    end

    assign sum   = p ^ c[SLICE_W-1:0];
    assign cout  = c[SLICE_W];
    assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/seq_adder_ctrl.sv
// rtl/seq_adder_ctrl.sv - byte-serial add/subtract controller around one 8-bit lookahead slice
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready only in IDLE
//   a, b, sub           operands and op select (0 = a+b, 1 = a-b)
//   out_valid/out_ready result handshake; result held in DONE until taken
//   sum, cout, overflow result, carry out (1 = no borrow on subtract), signed overflow

import seq_adder_ctrl_pkg::*;

module seq_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NS    = WIDTH / SLICE_W;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c_msb;

    assign slice_a = op_a[int'(idx)*SLICE_W +: SLICE_W];
    assign slice_b = op_b[int'(idx)*SLICE_W +: SLICE_W];

    Adder_LookAhead8 u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    if (in_valid && in_ready) begin
                        // Subtract is a + ~b + 1: invert B now, inject the +1 as carry-in.
                        op_a     <= a;
                        op_b     <= b ^ {WIDTH{sub}};
                        carry    <= sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    sum[int'(idx)*SLICE_W +: SLICE_W] <= slice_sum;
                    carry <= slice_cout;
                    if (idx == LAST_IDX) begin
                        cout      <= slice_cout;
                        // Signed overflow: carry into the MSB differs from carry out of it.
                        overflow  <= slice_c_msb ^ slice_cout;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_adder_ctrl.md
SEQ_ADDER_CTRL -- requirements
Module: seq_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; legal values are positive multiples of 8.
REQ-002 SHALL have port: clk  input  1  single system clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  request carries a valid operand pair.
REQ-005 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: sub  input  1  operation select: 0 = A+B, 1 = A-B.
REQ-009 SHALL have port: out_valid  output  1  result is valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: sum  output  WIDTH  result.
REQ-012 SHALL have port: cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 SHALL have port: overflow  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL compute the WIDTH-bit result with a single 8-bit carry-lookahead slice, reused once per byte, LSB byte first; NS = WIDTH/8.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 SHALL assert in_ready only in IDLE and deassert out_valid there.
REQ-017 On in_valid & in_ready, SHALL latch a, (b XOR {WIDTH{sub}}), carry = sub, byte index = 0, then go to RUN.
REQ-018 Each RUN cycle SHALL feed byte[idx] of both latched operands and the carry register into the slice.
REQ-019 Each RUN cycle SHALL write the slice sum into sum byte[idx] and the slice carry-out into the carry register, then increment idx.
REQ-020 SHALL go from RUN to DONE after the cycle in which idx = NS-1, so out_valid rises NS cycles after the accept edge (4 for WIDTH=32).
REQ-021 SHALL set cout to the final carry register and overflow to (carry into MSB) XOR (carry out of MSB), both registered at the last RUN cycle.
REQ-022 In DONE, SHALL hold out_valid=1 and keep sum, cout and overflow stable until out_ready=1.
REQ-023 On out_valid & out_ready, SHALL return to IDLE; in_ready SHALL be 1 in the following cycle; back-to-back throughput is one result per NS+2 cycles.
REQ-024 SHALL ignore in_valid, a, b and sub while in RUN or DONE; latched operands SHALL NOT change.
REQ-025 SHALL leave sum, cout and overflow holding the last result in IDLE until the next operation overwrites them.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, idx=0, carry=0, sum=0, cout=0, overflow=0, out_valid=0 and in_ready=0, regardless of clk.
REQ-027 SHALL assert in_ready=1 in the first cycle after rst deasserts.
REQ-028 SHALL abort an in-flight operation on reset mid-RUN or mid-DONE with no result delivered; the next accepted request SHALL compute correctly.

Structure
REQ-029 SHALL place state encodings (IDLE/RUN/DONE) and the SLICE_W=8 constant in the shared CPU package.
REQ-030 SHALL instantiate the existing Adder_LookAhead8 as the only sub-module; sequencing, registers and muxing live in seq_adder_ctrl.

Verification
REQ-031 SHALL cover: a=0x000000FF, b=0x00000001, sub=0 -> sum=0x00000100, cout=0, overflow=0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL cover: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, overflow=1.
REQ-033 SHALL cover: a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, overflow=0; and a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, overflow=0.
REQ-034 SHALL cover: out_ready held low 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> in_ready=1 next cycle.
REQ-035 SHALL cover: rst pulsed during 2nd RUN cycle -> outputs 0 asynchronously, no out_valid; then a=0x80000000, b=0x80000000, sub=0 -> sum=0, cout=1, overflow=1.
